// File: rtl/cpu_controller.sv
// Moore control FSM for a multicycle CPU: fetch, decode, ALU ops,
// immediate moves, LDR/STR with a memory handshake, conditional branch, halt.
module cpu_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic [1:0] ALU_op,
  input  logic [2:0] cond,
  input  logic [2:0] status,
  input  logic       mem_rdy,
  output logic [1:0] reg_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B,
  output logic [1:0] wb_sel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       load_addr,
  output logic       pc_sel,
  output logic       sel_addr,
  output logic [1:0] mem_cmd,
  output logic       halted
);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC,
    S_GETA, S_GETB, S_EXEC, S_WB, S_WBI,
    S_ADDR, S_LADDR, S_MRD, S_LWB,
    S_SRD, S_SC, S_MWR, S_BR, S_HALT
  } state_t;

  localparam logic [1:0] SEL_RM = 2'b00;
  localparam logic [1:0] SEL_RD = 2'b01;
  localparam logic [1:0] SEL_RN = 2'b10;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_t state;
  state_t state_next;

  // Instruction class decode from the (stable) IR fields.
  logic is_mov_imm, is_mov_reg, is_alu, is_ldr, is_str, is_branch;
  logic is_cmp, is_mvn, is_mem;
  logic flag_n, flag_v, flag_z, taken;

  assign is_mov_imm = (opcode == 3'b110) && (ALU_op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (ALU_op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_ldr     = (opcode == 3'b011) && (ALU_op == 2'b00);
  assign is_str     = (opcode == 3'b100) && (ALU_op == 2'b00);
  assign is_branch  = (opcode == 3'b001);
  assign is_cmp     = is_alu && (ALU_op == 2'b01);
  assign is_mvn     = is_alu && (ALU_op == 2'b11);
  assign is_mem     = is_ldr || is_str;

  assign flag_n = status[2];
  assign flag_v = status[1];
  assign flag_z = status[0];

  // Branch condition evaluation against the registered flags.
  always_comb begin
    unique case (cond)
      3'b000:  taken = 1'b1;
      3'b001:  taken = flag_z;
      3'b010:  taken = !flag_z;
      3'b011:  taken = flag_n ^ flag_v;
      3'b100:  taken = (flag_n ^ flag_v) | flag_z;
      default: taken = 1'b0;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values; blocking here would race other sequential blocks.
    if (!rst_n) state <= S_RST;
    else        state <= state_next;
  end

  // Next-state logic; only IF1, MRD and MWR look at mem_rdy.
  always_comb begin
    // NOTE: default assigned first so every path drives state_next; a missed branch would otherwise infer a latch.
    state_next = state;
    unique case (state)
      S_RST:   state_next = S_IF1;
      S_IF1:   if (mem_rdy) state_next = S_IF2;
      S_IF2:   state_next = S_UPC;
      S_UPC:   state_next = S_DEC;
      S_DEC: begin
        if      (is_mov_imm)        state_next = S_WBI;
        else if (is_mov_reg)        state_next = S_GETB;
        else if (is_alu || is_mem)  state_next = S_GETA;
        else if (is_branch)         state_next = S_BR;
        else                        state_next = S_HALT;
      end
      S_GETA:  state_next = is_mem ? S_ADDR : S_GETB;
      S_GETB:  state_next = S_EXEC;
      S_EXEC:  state_next = is_cmp ? S_IF1 : S_WB;
      S_WB:    state_next = S_IF1;
      S_WBI:   state_next = S_IF1;
      S_ADDR:  state_next = S_LADDR;
      S_LADDR: state_next = is_ldr ? S_MRD : S_SRD;
      S_MRD:   if (mem_rdy) state_next = S_LWB;
      S_LWB:   state_next = S_IF1;
      S_SRD:   state_next = S_SC;
      S_SC:    state_next = S_MWR;
      S_MWR:   if (mem_rdy) state_next = S_IF1;
      S_BR:    state_next = S_IF1;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_RST;
    endcase
  end

  // Moore output decode; everything not named for a state stays 0.
  always_comb begin
    reg_sel   = SEL_RM;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    wb_sel    = 2'b00;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    pc_sel    = 1'b0;
    sel_addr  = 1'b0;
    mem_cmd   = CMD_NONE;
    halted    = 1'b0;
    unique case (state)
      S_RST:   begin load_pc = 1'b1; reset_pc = 1'b1; end
      S_IF1:   mem_cmd = CMD_READ;
      S_IF2:   load_ir = 1'b1;
      S_UPC:   load_pc = 1'b1;
      S_DEC:   ;
      S_GETA:  begin reg_sel = SEL_RN; en_A = 1'b1; end
      S_GETB:  begin reg_sel = SEL_RM; en_B = 1'b1; end
      S_EXEC: begin
        en_C      = 1'b1;
        sel_A     = is_mov_reg || is_mvn;
        en_status = is_cmp;
      end
      S_WB:    begin reg_sel = SEL_RD; w_en = 1'b1; wb_sel = 2'b00; end
      S_WBI:   begin reg_sel = SEL_RN; w_en = 1'b1; wb_sel = 2'b10; end
      S_ADDR:  begin sel_B = 1'b1; en_C = 1'b1; end
      S_LADDR: load_addr = 1'b1;
      S_MRD:   begin mem_cmd = CMD_READ; sel_addr = 1'b1; end
      S_LWB:   begin reg_sel = SEL_RD; w_en = 1'b1; wb_sel = 2'b11; end
      S_SRD:   begin reg_sel = SEL_RD; en_B = 1'b1; end
      S_SC:    begin sel_A = 1'b1; en_C = 1'b1; end
      S_MWR:   begin mem_cmd = CMD_WRITE; sel_addr = 1'b1; end
      S_BR:    begin load_pc = 1'b1; pc_sel = taken; end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed scenarios then random
// instructions, compared cycle by cycle against a phase-list model.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] opcode = '0;
  logic [1:0] ALU_op = '0;
  logic [2:0] cond = '0;
  logic [2:0] status = '0;
  logic       mem_rdy = 1'b0;
  logic [1:0] reg_sel;
  logic       w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
  logic [1:0] wb_sel;
  logic       load_ir, load_pc, reset_pc, load_addr, pc_sel, sel_addr;
  logic [1:0] mem_cmd;
  logic       halted;

  cpu_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .ALU_op(ALU_op), .cond(cond),
    .status(status), .mem_rdy(mem_rdy), .reg_sel(reg_sel), .w_en(w_en),
    .en_A(en_A), .en_B(en_B), .en_C(en_C), .en_status(en_status),
    .sel_A(sel_A), .sel_B(sel_B), .wb_sel(wb_sel), .load_ir(load_ir),
    .load_pc(load_pc), .reset_pc(reset_pc), .load_addr(load_addr),
    .pc_sel(pc_sel), .sel_addr(sel_addr), .mem_cmd(mem_cmd), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] reg_sel;
    logic       w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
    logic [1:0] wb_sel;
    logic       load_ir, load_pc, reset_pc, load_addr, pc_sel, sel_addr;
    logic [1:0] mem_cmd;
    logic       halted;
  } outs_t;

  typedef struct {
    string name;
    outs_t o;
    int    rdy;   // -1 = don't care (random), else value to drive
  } step_t;

  outs_t got;
  always_comb got = {reg_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B,
                     wb_sel, load_ir, load_pc, reset_pc, load_addr, pc_sel,
                     sel_addr, mem_cmd, halted};

  int    total = 0;
  int    bad   = 0;
  step_t exp_q[$];

  // Expected outputs of each phase, taken from the output table.
  function automatic outs_t mk(string ph, bit tk, bit cmp, bit sa);
    outs_t o = '0;
    case (ph)
      "RST":   begin o.load_pc = 1; o.reset_pc = 1; end
      "IF1":   o.mem_cmd = 2'b01;
      "IF2":   o.load_ir = 1;
      "UPC":   o.load_pc = 1;
      "GETA":  begin o.reg_sel = 2'b10; o.en_A = 1; end
      "GETB":  o.en_B = 1;
      "EXEC":  begin o.en_C = 1; o.sel_A = sa; o.en_status = cmp; end
      "WB":    begin o.reg_sel = 2'b01; o.w_en = 1; end
      "WBI":   begin o.reg_sel = 2'b10; o.w_en = 1; o.wb_sel = 2'b10; end
      "ADDR":  begin o.sel_B = 1; o.en_C = 1; end
      "LADDR": o.load_addr = 1;
      "MRD":   begin o.mem_cmd = 2'b01; o.sel_addr = 1; end
      "LWB":   begin o.reg_sel = 2'b01; o.w_en = 1; o.wb_sel = 2'b11; end
      "SRD":   begin o.reg_sel = 2'b01; o.en_B = 1; end
      "SC":    begin o.sel_A = 1; o.en_C = 1; end
      "MWR":   begin o.mem_cmd = 2'b10; o.sel_addr = 1; end
      "BR":    begin o.load_pc = 1; o.pc_sel = tk; end
      "HALT":  o.halted = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic void push(string ph, int rdy, bit tk = 0, bit cmp = 0, bit sa = 0);
    step_t s;
    s.name = ph;
    s.o    = mk(ph, tk, cmp, sa);
    s.rdy  = rdy;
    exp_q.push_back(s);
  endfunction

  function automatic void push_wait(string ph, int waits);
    for (int i = 0; i < waits; i++) push(ph, 0);
    push(ph, 1);
  endfunction

  function automatic bit branch_taken(logic [2:0] c, logic [2:0] st);
    bit n = st[2], v = st[1], z = st[0];
    bit lt = (n != v);
    case (c)
      3'd0: return 1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return lt;
      3'd4: return lt || z;
      default: return 0;
    endcase
  endfunction

  task automatic check(string tag, outs_t exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Holds reset for n cycles (checking RST each cycle), then releases it;
  // returns just after the edge that enters IF1.
  task automatic do_reset(int n, string tag);
    @(negedge clk);
    rst_n   = 1'b0;
    mem_rdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s_rst%0d", tag, i), mk("RST", 0, 0, 0));
    end
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  // Builds the expected phase list for one instruction and walks it.
  // Returns 1 if the instruction ends in HALT (or was aborted), so the caller resets.
  task automatic run(input logic [2:0] op, input logic [1:0] alu, input logic [2:0] cnd,
                     input logic [2:0] st, input int ifw, input int memw,
                     input bit abort, input string tag, output bit need_reset);
    bit mvn  = (op == 3'b101) && (alu == 2'b11);
    bit cmp  = (op == 3'b101) && (alu == 2'b01);
    bit movr = (op == 3'b110) && (alu == 2'b00);
    need_reset = 0;
    exp_q.delete();
    push_wait("IF1", ifw);
    push("IF2", -1); push("UPC", -1); push("DEC", -1);
    if (op == 3'b110 && alu == 2'b10) begin
      push("WBI", -1);
    end else if (movr) begin
      push("GETB", -1); push("EXEC", -1, 0, 0, 1); push("WB", -1);
    end else if (op == 3'b101) begin
      push("GETA", -1); push("GETB", -1); push("EXEC", -1, 0, cmp, mvn);
      if (!cmp) push("WB", -1);
    end else if (op == 3'b011 && alu == 2'b00) begin
      push("GETA", -1); push("ADDR", -1); push("LADDR", -1);
      push_wait("MRD", memw); push("LWB", -1);
    end else if (op == 3'b100 && alu == 2'b00) begin
      push("GETA", -1); push("ADDR", -1); push("LADDR", -1);
      push("SRD", -1); push("SC", -1);
      if (abort) begin
        push("MWR", 0); push("MWR", 0);
        need_reset = 1;
      end else begin
        push_wait("MWR", memw);
      end
    end else if (op == 3'b001) begin
      push("BR", -1, branch_taken(cnd, st));
    end else begin
      for (int i = 0; i < 10; i++) push("HALT", -1);
      need_reset = 1;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        opcode = op; ALU_op = alu; cond = cnd; status = st;
      end
      check($sformatf("%s_%0d_%s", tag, i, exp_q[i].name), exp_q[i].o);
      mem_rdy = (exp_q[i].rdy < 0) ? 1'($urandom_range(0, 1)) : 1'(exp_q[i].rdy);
      @(posedge clk);
    end
  endtask

  initial begin
    bit nr;
    logic [2:0] op, cnd, st;
    logic [1:0] alu;
    do_reset(3, "init");
    run(3'b110, 2'b10, 3'd0, 3'b000, 0, 0, 0, "movi", nr);
    run(3'b101, 2'b00, 3'd0, 3'b000, 2, 0, 0, "add", nr);
    run(3'b101, 2'b01, 3'd0, 3'b000, 0, 0, 0, "cmp", nr);
    run(3'b101, 2'b11, 3'd0, 3'b000, 0, 0, 0, "mvn", nr);
    run(3'b110, 2'b00, 3'd0, 3'b000, 0, 0, 0, "movr", nr);
    run(3'b011, 2'b00, 3'd0, 3'b000, 0, 3, 0, "ldr", nr);
    run(3'b100, 2'b00, 3'd0, 3'b000, 1, 2, 0, "str", nr);
    run(3'b001, 2'b00, 3'd1, 3'b001, 0, 0, 0, "beq_t", nr);
    run(3'b001, 2'b00, 3'd1, 3'b000, 0, 0, 0, "beq_n", nr);
    run(3'b001, 2'b00, 3'd3, 3'b100, 0, 0, 0, "blt_t", nr);
    run(3'b001, 2'b00, 3'd4, 3'b110, 0, 0, 0, "ble_n", nr);
    run(3'b001, 2'b00, 3'd6, 3'b001, 0, 0, 0, "bnv", nr);
    run(3'b100, 2'b00, 3'd0, 3'b000, 0, 5, 1, "str_abort", nr);
    do_reset(2, "mwr_abort");
    run(3'b111, 2'b00, 3'd0, 3'b000, 0, 0, 0, "halt111", nr);
    do_reset(1, "halt111");
    run(3'b010, 2'b00, 3'd0, 3'b000, 0, 0, 0, "halt010", nr);
    do_reset(1, "halt010");

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        op = 3'($urandom_range(0, 7)); alu = 2'($urandom_range(0, 3));
      end else begin
        case ($urandom_range(0, 5))
          0: begin op = 3'b110; alu = 2'b10; end
          1: begin op = 3'b110; alu = 2'b00; end
          2: begin op = 3'b101; alu = 2'($urandom_range(0, 3)); end
          3: begin op = 3'b011; alu = 2'b00; end
          4: begin op = 3'b100; alu = 2'b00; end
          default: begin op = 3'b001; alu = 2'($urandom_range(0, 3)); end
        endcase
      end
      cnd = 3'($urandom_range(0, 7));
      st  = 3'($urandom_range(0, 7));
      run(op, alu, cnd, st, $urandom_range(0, 3), $urandom_range(0, 4),
          ($urandom_range(0, 9) == 0), $sformatf("rnd%0d", k), nr);
      if (nr) do_reset($urandom_range(1, 2), $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
